// File: rtl/mem_load_ctrl.sv
// Packet controller for the SNN parameter memory: decodes CMD/ADDR/LEN,
// writes bytes with auto-increment and streams readback over valid/ready.
module mem_load_ctrl #(
   parameter int DEPTH   = 101,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [7:0]         byte_in,
   input  logic               byte_valid,
   output logic [6:0]         mem_addr,
   output logic [7:0]         mem_data,
   output logic               mem_we,
   input  logic [DEPTH*8-1:0] all_data_in,
   output logic [7:0]         tx_byte,
   output logic               tx_valid,
   input  logic               tx_ready,
   input  logic               clr_err,
   output logic               busy,
   output logic               done,
   output logic [2:0]         err
);

   localparam logic [8:0] LP_DEPTH = 9'(DEPTH);
   localparam logic [7:0] LP_TLAST = 8'(TIMEOUT - 1);
   localparam logic [7:0] CMD_WR   = 8'h01;
   localparam logic [7:0] CMD_RD   = 8'h02;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_LEN, S_WRITE, S_READ
   } state_t;

   state_t        r_state;
   logic [8:0]    r_cur;
   logic [7:0]    r_rem;
   logic [7:0]    r_tmo;
   logic          r_rd;

   logic          w_oor;
   logic          w_timed;
   logic          w_bad;
   logic          w_hdr;
   logic [2:0]    w_set;
   logic [1023:0] w_pad;
   logic [7:0]    w_rd_byte;

   assign busy    = (r_state != S_IDLE);
   assign w_oor   = (r_cur >= LP_DEPTH);
   assign w_hdr   = (r_state == S_ADDR) || (r_state == S_LEN) ||
                    (r_state == S_WRITE);
   assign w_timed = w_hdr && !byte_valid && (r_tmo == LP_TLAST);
   assign w_bad   = (r_state == S_IDLE) && byte_valid &&
                    (byte_in != CMD_WR) && (byte_in != CMD_RD);
   assign w_set   = {w_timed,
                     w_oor && ((r_state == S_WRITE && byte_valid) ||
                               (r_state == S_READ && !tx_valid)),
                     w_bad};

   // Zero-pad the flat bus so a 7-bit pointer can index it safely.
   assign w_pad     = {{(1024 - DEPTH*8){1'b0}}, all_data_in};
   assign w_rd_byte = w_oor ? 8'h00 : w_pad[{r_cur[6:0], 3'b000} +: 8];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_cur    <= '0;
         r_rem    <= '0;
         r_tmo    <= '0;
         r_rd     <= 1'b0;
         mem_addr <= '0;
         mem_data <= '0;
         mem_we   <= 1'b0;
         tx_byte  <= '0;
         tx_valid <= 1'b0;
         done     <= 1'b0;
         err      <= '0;
      end else begin
         mem_we <= 1'b0;
         done   <= 1'b0;
         err    <= (clr_err ? 3'b000 : err) | w_set;
         r_tmo  <= (byte_valid || !busy) ? 8'd0 : r_tmo + 8'd1;
         if (w_timed) begin
            r_state <= S_IDLE;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  if (byte_valid && !w_bad) begin
                     r_rd    <= (byte_in == CMD_RD);
                     r_state <= S_ADDR;
                  end
               end
               S_ADDR: begin
                  if (byte_valid) begin
                     r_cur   <= {1'b0, byte_in};
                     r_state <= S_LEN;
                  end
               end
               S_LEN: begin
                  if (byte_valid) begin
                     r_rem <= byte_in;
                     if (byte_in == 8'd0) begin
                        done    <= 1'b1;
                        r_state <= S_IDLE;
                     end else begin
                        r_state <= r_rd ? S_READ : S_WRITE;
                     end
                  end
               end
               S_WRITE: begin
                  if (byte_valid) begin
                     mem_we   <= !w_oor;
                     mem_addr <= r_cur[6:0];
                     mem_data <= byte_in;
                     r_cur    <= r_cur + 9'd1;
                     r_rem    <= r_rem - 8'd1;
                     if (r_rem == 8'd1) begin
                        done    <= 1'b1;
                        r_state <= S_IDLE;
                     end
                  end
               end
               S_READ: begin
                  if (!tx_valid) begin
                     tx_byte  <= w_rd_byte;
                     tx_valid <= 1'b1;
                  end else if (tx_ready) begin
                     tx_valid <= 1'b0;
                     r_cur    <= r_cur + 9'd1;
                     r_rem    <= r_rem - 8'd1;
                     if (r_rem == 8'd1) begin
                        done    <= 1'b1;
                        r_state <= S_IDLE;
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
